// File: rtl/mulmod12289_arbiter.sv
// Round-robin shared signed 14x14 multiply with 3-stage centered mod-12289 reduction; result 4 cycles after accept.
// No internal stalls: drain only blocks new grants, and every res_valid pulse must be sunk by its requester.
module mulmod12289_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [NREQ-1:0]        i_req_valid,
    output logic [NREQ-1:0]        o_req_ready,
    input  logic [NREQ*14-1:0]     i_req_a,
    input  logic [NREQ*14-1:0]     i_req_b,
    input  logic [NREQ*IDW-1:0]    i_req_id,
    input  logic                   i_drain,
    output logic [NREQ-1:0]        o_res_valid,
    output logic signed [13:0]     o_res_z,
    output logic [IDW-1:0]         o_res_id,
    output logic                   o_busy,
    output logic                   o_err
);
    localparam int          IW        = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [27:0] Q         = 28'd12289;
    // 5462*q exceeds 2^26, so adding it makes every 27-bit product non-negative.
    localparam logic [27:0] OFFSET    = 28'd67122518;
    localparam logic [54:0] BARRETT_M = 55'((55'd1 << 40) / 55'd12289);

    logic [NREQ-1:0]    w_grant;
    logic [IW-1:0]      w_gidx;
    logic               w_found;
    logic [IW:0]        w_sum;
    logic               w_xfer;
    logic [IW-1:0]      r_ptr;

    logic signed [13:0] w_a;
    logic signed [13:0] w_b;
    logic               w_oor;

    logic signed [26:0] r_p1;
    logic [27:0]        w_u;
    logic [13:0]        w_q;
    logic [27:0]        r_u2;
    logic [13:0]        r_q2;
    logic [14:0]        w_r3;
    logic [13:0]        r_r3;
    logic [13:0]        r_z4;

    logic               r_vld [1:4];
    logic [IW-1:0]      r_idx [1:4];
    logic [IDW-1:0]     r_id  [1:4];

    logic [NREQ-1:0]    w_res_oh;
    logic [NREQ-1:0]    r_res_valid;
    logic [13:0]        r_res_z;
    logic [IDW-1:0]     r_res_id;
    logic               r_err;

    // Search starts at the rr pointer and wraps once around the requesters.
    always_comb begin
        w_grant = '0;
        w_gidx  = '0;
        w_found = 1'b0;
        w_sum   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_sum = {1'b0, r_ptr} + (IW+1)'(k);
            if (w_sum >= (IW+1)'(NREQ)) begin
                w_sum = w_sum - (IW+1)'(NREQ);
            end
            if (!w_found && i_req_valid[w_sum[IW-1:0]]) begin
                w_found                 = 1'b1;
                w_gidx                  = w_sum[IW-1:0];
                w_grant[w_sum[IW-1:0]]  = 1'b1;
            end
        end
    end

    assign o_req_ready = (i_rst || i_drain) ? '0 : w_grant;
    assign w_xfer      = w_found && !i_rst && !i_drain;

    assign w_a   = i_req_a[w_gidx*14 +: 14];
    assign w_b   = i_req_b[w_gidx*14 +: 14];
    assign w_oor = (w_a < -14'sd6144) || (w_a > 14'sd6144) ||
                   (w_b < -14'sd6144) || (w_b > 14'sd6144);

    // Barrett quotient undershoots by at most one, so stage 3 needs a single correction.
    assign w_u  = {r_p1[26], r_p1} + OFFSET;
    assign w_q  = 14'(({27'd0, w_u} * BARRETT_M) >> 40);
    assign w_r3 = 15'(r_u2 - ({14'd0, r_q2} * Q));

    always_comb begin
        w_res_oh = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_res_oh[i] = r_vld[4] && (r_idx[4] == IW'(i));
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr       <= '0;
            r_err       <= 1'b0;
            r_res_valid <= '0;
            r_res_z     <= '0;
            r_res_id    <= '0;
            for (int s = 1; s <= 4; s++) begin
                r_vld[s] <= 1'b0;
            end
        end else begin
            if (w_xfer) begin
                r_ptr <= (w_gidx == IW'(NREQ-1)) ? '0 : w_gidx + 1'b1;
                if (w_oor) begin
                    r_err <= 1'b1;
                end
            end
            r_vld[1] <= w_xfer;
            for (int s = 2; s <= 4; s++) begin
                r_vld[s] <= r_vld[s-1];
            end
            r_res_valid <= w_res_oh;
            if (r_vld[4]) begin
                r_res_z  <= r_z4;
                r_res_id <= r_id[4];
            end
        end
    end

    // Datapath and tag payload advance unconditionally; validity lives in r_vld.
    always_ff @(posedge i_clk) begin
        r_p1     <= 27'(w_a) * 27'(w_b);
        r_idx[1] <= w_gidx;
        r_id[1]  <= i_req_id[w_gidx*IDW +: IDW];
        for (int s = 2; s <= 4; s++) begin
            r_idx[s] <= r_idx[s-1];
            r_id[s]  <= r_id[s-1];
        end
        r_u2 <= w_u;
        r_q2 <= w_q;
        r_r3 <= (w_r3 >= 15'd12289) ? 14'(w_r3 - 15'd12289) : w_r3[13:0];
        r_z4 <= (r_r3 > 14'd6144) ? r_r3 + 14'd4095 : r_r3;
    end

    assign o_res_valid = r_res_valid;
    assign o_res_z     = r_res_z;
    assign o_res_id    = r_res_id;
    assign o_busy      = r_vld[1] | r_vld[2] | r_vld[3] | r_vld[4];
    assign o_err       = r_err;

endmodule

// File: tb/tb_mulmod12289_arbiter.sv
// Directed bench for mulmod12289_arbiter: stimulus pushes expected results, a negedge monitor pops and compares.
module tb_mulmod12289_arbiter;
    localparam int NREQ = 2;
    localparam int IDW  = 8;

    logic        i_clk       = 1'b0;
    logic        i_rst       = 1'b1;
    logic        i_drain     = 1'b0;
    logic [1:0]  i_req_valid = 2'b11;
    logic [27:0] i_req_a     = '0;
    logic [27:0] i_req_b     = '0;
    logic [15:0] i_req_id    = '0;
    logic [1:0]  o_req_ready;
    logic [1:0]  o_res_valid;
    logic [13:0] o_res_z;
    logic [7:0]  o_res_id;
    logic        o_busy;
    logic        o_err;

    int cyc   = 0;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int         edge_n;
        logic [1:0] oh;
        logic [7:0] id;
        logic [13:0] z;
        bit         chk_z;
    } exp_t;
    exp_t exp_q[$];

    logic signed [13:0] fz [8] = '{14'sd2, -14'sd6, 14'sd6, -14'sd12,
                                   14'sd10, -14'sd18, 14'sd14, -14'sd24};
    logic [1:0]         frdy [8] = '{2'b01, 2'b10, 2'b01, 2'b10,
                                     2'b01, 2'b10, 2'b01, 2'b10};

    mulmod12289_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_req_a     (i_req_a),
        .i_req_b     (i_req_b),
        .i_req_id    (i_req_id),
        .i_drain     (i_drain),
        .o_res_valid (o_res_valid),
        .o_res_z     (o_res_z),
        .o_res_id    (o_res_id),
        .o_busy      (o_busy),
        .o_err       (o_err)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One cycle of stimulus; exp_rdy is the grant this bench expects, and a grant queues a result.
    task automatic op(input logic [1:0] vld, input logic drn, input logic [1:0] exp_rdy,
                      input logic signed [13:0] a0, input logic signed [13:0] b0, input logic [7:0] id0,
                      input logic signed [13:0] a1, input logic signed [13:0] b1, input logic [7:0] id1,
                      input logic signed [13:0] exp_z, input bit chk_z = 1'b1);
        exp_t e;
        @(negedge i_clk);
        i_req_valid = vld;
        i_drain     = drn;
        i_req_a     = {a1, a0};
        i_req_b     = {b1, b0};
        i_req_id    = {id1, id0};
        #1;
        chk("req_ready", 32'(o_req_ready), 32'(exp_rdy));
        if (exp_rdy != 2'b00) begin
            e.edge_n = cyc + 1;
            e.oh     = exp_rdy;
            e.id     = exp_rdy[1] ? id1 : id0;
            e.z      = exp_z;
            e.chk_z  = chk_z;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input int n, input logic drn);
        repeat (n) begin
            @(negedge i_clk);
            i_req_valid = 2'b00;
            i_drain     = drn;
        end
    endtask

    initial begin
        forever begin
            @(negedge i_clk);
            if (o_res_valid !== 2'b00) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_res_valid", 32'(o_res_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("res_valid", 32'(o_res_valid), 32'(e.oh));
                    chk("res_id", 32'(o_res_id), 32'(e.id));
                    if (e.chk_z) chk("res_z", 32'(o_res_z), 32'(e.z));
                    chk("latency", 32'(cyc - e.edge_n), 32'd4);
                end
            end
        end
    end

    initial begin
        // Reset state, with both requesters asserting valid.
        repeat (2) @(negedge i_clk);
        #1;
        chk("rst_req_ready", 32'(o_req_ready), 32'd0);
        chk("rst_res_valid", 32'(o_res_valid), 32'd0);
        chk("rst_res_z", 32'(o_res_z), 32'd0);
        chk("rst_res_id", 32'(o_res_id), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_err", 32'(o_err), 32'd0);
        @(negedge i_clk);
        i_rst       = 1'b0;
        i_req_valid = 2'b00;

        // Single op from requester 0.
        op(2'b01, 1'b0, 2'b01, 14'sd3, 14'sd5, 8'h11, 14'sd0, 14'sd0, 8'h00, 14'sd15);
        for (int j = 0; j < 5; j++) begin
            idle(1, 1'b0);
            chk("busy_single", 32'(o_busy), 32'(j < 4));
        end
        idle(2, 1'b0);
        chk("res_z_hold", 32'(o_res_z), 32'd15);
        chk("res_id_hold", 32'(o_res_id), 32'h11);

        // Reduction corner values, lone requester 1 granted every cycle.
        op(2'b10, 1'b0, 2'b10, 14'sd0, 14'sd0, 8'h00, 14'sd100,  14'sd123,   8'h21, 14'sd11);
        op(2'b10, 1'b0, 2'b10, 14'sd0, 14'sd0, 8'h00, 14'sd6144, 14'sd6144,  8'h22, -14'sd3072);
        op(2'b10, 1'b0, 2'b10, 14'sd0, 14'sd0, 8'h00, -14'sd1,   14'sd1,     8'h23, -14'sd1);
        op(2'b10, 1'b0, 2'b10, 14'sd0, 14'sd0, 8'h00, 14'sd0,    -14'sd6144, 8'h24, 14'sd0);
        idle(6, 1'b0);

        // Fairness: both requesters valid for 8 cycles.
        for (int k = 0; k < 8; k++) begin
            op(2'b11, 1'b0, frdy[k],
               14'(k + 1), 14'sd2, 8'(32'h40 + k),
               14'(-(k + 1)), 14'sd3, 8'(32'h80 + k),
               fz[k]);
        end
        idle(6, 1'b0);

        // Drain with three ops in flight, then resume at the saved pointer.
        op(2'b11, 1'b0, 2'b01, 14'sd7,   14'sd8,   8'h51, 14'sd0,  14'sd0,  8'h61, 14'sd56);
        op(2'b11, 1'b0, 2'b10, 14'sd0,   14'sd0,   8'h52, -14'sd9, 14'sd10, 8'h62, -14'sd90);
        op(2'b11, 1'b0, 2'b01, 14'sd111, 14'sd111, 8'h53, 14'sd0,  14'sd0,  8'h63, 14'sd32);
        for (int j = 0; j < 5; j++) begin
            op(2'b11, 1'b1, 2'b00, 14'sd1, 14'sd1, 8'h54, 14'sd1, 14'sd1, 8'h64, 14'sd0);
            chk("busy_drain", 32'(o_busy), 32'(j < 4));
        end
        op(2'b11, 1'b0, 2'b10, 14'sd0, 14'sd0, 8'h55, 14'sd2000, 14'sd7, 8'h65, 14'sd1711);
        idle(6, 1'b0);

        // Reset two cycles after the first of two accepts: nothing may emerge.
        op(2'b01, 1'b0, 2'b01, 14'sd10, 14'sd10, 8'h71, 14'sd0, 14'sd0, 8'h00, 14'sd100);
        op(2'b01, 1'b0, 2'b01, 14'sd20, 14'sd20, 8'h72, 14'sd0, 14'sd0, 8'h00, 14'sd400);
        @(negedge i_clk);
        i_rst       = 1'b1;
        i_req_valid = 2'b11;
        exp_q.delete();
        #1;
        chk("midrst_req_ready", 32'(o_req_ready), 32'd0);
        @(negedge i_clk);
        #1;
        chk("midrst_res_valid", 32'(o_res_valid), 32'd0);
        chk("midrst_res_z", 32'(o_res_z), 32'd0);
        chk("midrst_res_id", 32'(o_res_id), 32'd0);
        chk("midrst_busy", 32'(o_busy), 32'd0);
        @(negedge i_clk);
        i_rst       = 1'b0;
        i_req_valid = 2'b00;
        idle(8, 1'b0);
        op(2'b11, 1'b0, 2'b01, -14'sd6144, 14'sd6144, 8'h73, 14'sd5, 14'sd5, 8'h74, 14'sd3072);
        idle(6, 1'b0);

        // Sticky range error.
        chk("err_before", 32'(o_err), 32'd0);
        op(2'b01, 1'b0, 2'b01, 14'sd6145, 14'sd1, 8'h81, 14'sd0, 14'sd0, 8'h00, 14'sd0, 1'b0);
        op(2'b01, 1'b0, 2'b01, 14'sd1, 14'sd1, 8'h82, 14'sd0, 14'sd0, 8'h00, 14'sd1);
        chk("err_set", 32'(o_err), 32'd1);
        idle(6, 1'b0);
        chk("err_sticky", 32'(o_err), 32'd1);
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        #1;
        chk("err_cleared", 32'(o_err), 32'd0);
        i_rst = 1'b0;
        idle(3, 1'b0);

        chk("results_pending", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mulmod12289_arbiter.md
# mulmod12289_arbiter

Shares one signed 14×14 multiplier plus one 3-stage mod-12289 reduction pipeline between NREQ requesters (NTT butterfly, pointwise multiply, twiddle precompute). Accepts at most one operand pair per cycle by round-robin arbitration, carries requester index and user ID alongside the data, and returns each centered residue to its requester after a fixed 4-cycle latency. Results have no backpressure; requesters must sink every `res_valid` pulse.

## Interface
- NREQ, 2, number of requesters (supported 2..4)
- IDW, 8, width of user ID carried with each operation
- clk  in  1  clock; all logic rising-edge
- rst  in  1  synchronous reset, active-high
- req_valid  in  NREQ  per-requester operand valid
- req_ready  out  NREQ  one-hot grant; combinational from req_valid, rr pointer, drain, rst
- req_a  in  NREQ*14  signed operand A per requester (slot i = bits 14i+13:14i)
- req_b  in  NREQ*14  signed operand B per requester
- req_id  in  NREQ*IDW  user ID per requester
- drain  in  1  when high, no new grants; in-flight operations complete
- res_valid  out  NREQ  one-hot, one-cycle pulse per completed operation
- res_z  out  14  shared result bus, signed, ≡ a·b mod 12289, range [-6144, 6144]
- res_id  out  IDW  ID of the operation on res_z
- busy  out  1  any operation in flight (stages 1-4)
- err  out  1  sticky: an accepted operand was outside [-6144, 6144]

## Operation
- Stage 0 (arbitrate): rr pointer p (reset 0). Grant the first i in p, p+1, …, p+NREQ-1 (mod NREQ) with req_valid[i]. req_ready = that one-hot, or 0 when drain or rst. Transfer = req_valid & req_ready.
- After a transfer from requester g, p <= (g+1) mod NREQ; no transfer leaves p unchanged.
- Stage 1: register product a·b as 27-bit signed (|a|,|b| ≤ 6144 gives |a·b| < 2^26).
- Stages 2-4: reduction pipeline; output signed 14-bit centered residue in [-6144, 6144].
- Tag pipeline, 4 deep: {valid, requester index, id}, advanced every cycle with the data; no stall.
- Stage 4 output: res_valid[idx] = tag valid; res_z/res_id driven from the stage; when tag invalid, res_valid = 0 and res_z/res_id hold their previous values.
- err set on a transfer where either operand is < -6144 or > 6144; cleared only by rst. Out-of-range operations still run; their result is unspecified.
- busy = OR of tag valids in stages 1-4.
- drain does not flush; it only blocks stage 0. busy falls 4 cycles after the last accept.

## Timing
- Reset values: res_valid 0, res_z 0, res_id 0, busy 0, err 0, p 0, all tag valids 0.
- Latency: transfer on edge k -> res_valid high for exactly the cycle after edge k+4.
- Throughput: one transfer per cycle aggregate; a lone active requester is granted every cycle.
- All NREQ active continuously: grants rotate 0,1,…,NREQ-1; each requester gets exactly 1/NREQ.
- rst mid-operation: all in-flight operations discarded, no res_valid for them. During rst, req_ready = 0.
- drain and req_valid in the same cycle: no grant; p unchanged.
- Result order equals accept order; IDs are never reordered.

## Test plan
- Single op: req 0 sends a=3, b=5, id=0x11 at edge 0 -> res_valid[0] at edge 4, res_z=15, res_id=0x11; busy high cycles 1-4.
- Reduction values (back-to-back from req 1): (100,123) -> 11; (6144,6144) -> -3072; (-1,1) -> -1 (0x3FFF); (0,-6144) -> 0. Results on 4 consecutive cycles, in order.
- Fairness: NREQ=2, both valid every cycle for 8 cycles with IDs incrementing -> grants alternate 0,1,0,1…, starting at 0 after reset; 8 results with per-requester IDs in order.
- drain: assert drain with 3 ops in flight -> req_ready=0, the 3 results still emerge, busy drops 4 cycles after the last accept; deassert -> grant resumes at pointer p.
- Reset mid-flight: 2 ops accepted, rst at edge 2 -> no res_valid afterward; all outputs at reset values; the first post-reset op has 4-cycle latency, granted to req 0 first.
- Range error: accept a=6145, b=1 -> err=1 next cycle and stays high through later valid ops until rst.
